// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // Word-aligned address: the memory bus only ever sees bits [1:0] == 0.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Response watchdog: counts cycles while enabled, flags the last permitted cycle.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired_c = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturates at the expiry value so a held enable cannot wrap the counter.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired_c) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding word read over req/gnt + rvalid, with flush kill and watchdog.
// Optional FETCH_MISALIGN_TRAP_EN answers misaligned PCs locally with a NOP and fetch_misaligned.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic            CLK,
  input  logic            resetn,
  input  logic [XLEN-1:0] PC,
  input  logic            fetch_enable,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] instr_fetch,
  output logic            fetch_valid,
  output logic            fetch_timeout
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned
`endif
);

  fetch_state_t    state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            timeout_q, timeout_d;
  logic            kill_q, kill_d;
  logic            misaligned_c;
  logic            wd_expired_c;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misaligned_q, misaligned_d;

  assign misaligned_c     = (PC[1:0] != 2'b00);
  assign fetch_misaligned = misaligned_q;
`else
  logic            unused_pc_lsbs;

  assign misaligned_c   = 1'b0;
  assign unused_pc_lsbs = ^PC[1:0];
`endif

  // Watchdog only runs in WAIT and restarts from zero on every WAIT entry.
  fetch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk       (CLK),
    .rst_n     (resetn),
    .clear     (state_q != WAIT),
    .enable    (state_q == WAIT),
    .expired_c (wd_expired_c)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    fetch_valid_d = 1'b0;
    timeout_d     = timeout_q;
    kill_d        = kill_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (fetch_enable && !flush) begin
          if (misaligned_c) begin
            // Trap pulses are spaced so fetch_valid never stays high two cycles.
            if (!fetch_valid_q) begin
              fetch_valid_d = 1'b1;
              instr_d       = NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
              misaligned_d  = 1'b1;
`endif
            end
          end else begin
            mem_addr_d = word_align(PC);
            mem_req_d  = 1'b1;
            state_d    = REQ;
          end
        end
      end

      REQ: begin
        kill_d = kill_q | flush;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = (kill_q || flush) ? DROP : WAIT;
        end
      end

      WAIT: begin
        if (mem_rvalid) begin
          if (!flush) begin
            instr_d       = mem_rdata;
            fetch_valid_d = 1'b1;
          end
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end else if (wd_expired_c) begin
          timeout_d = 1'b1;
          state_d   = DROP;
        end
      end

      DROP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      fetch_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      kill_q        <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      fetch_valid_q <= fetch_valid_d;
      timeout_q     <= timeout_d;
      kill_q        <= kill_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q  <= misaligned_d;
`endif
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign instr_fetch   = instr_q;
  assign fetch_valid   = fetch_valid_q;
  assign fetch_timeout = timeout_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard queue checked by a negedge monitor.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        resetn;
  logic [31:0] PC;
  logic        fetch_enable;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr_fetch;
  logic        fetch_valid;
  logic        fetch_timeout;
  logic        fetch_misaligned_w;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sb_q[$];
  logic        prev_valid = 1'b0;

  instr_fetch_unit #(.TIMEOUT_CYCLES(8)) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .PC            (PC),
    .fetch_enable  (fetch_enable),
    .flush         (flush),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .instr_fetch   (instr_fetch),
    .fetch_valid   (fetch_valid),
    .fetch_timeout (fetch_timeout)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned_w)
`endif
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned_w = 1'b0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every fetch_valid pulse must match the oldest expected entry.
  always @(negedge CLK) begin
    if (resetn && fetch_valid) begin
      chk("no_back_to_back_valid", {31'd0, prev_valid}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_fetch_valid", instr_fetch, 32'hFFFF_FFFF ^ instr_fetch);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("sb_instr", instr_fetch, e[31:0]);
        chk("sb_misaligned", {31'd0, fetch_misaligned_w}, {31'd0, e[32]});
      end
    end
    prev_valid = resetn && fetch_valid;
  end

  // Full fetch: grant after gnt_dly extra cycles, rvalid rv_dly cycles after grant.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] exp_addr,
                          input int gnt_dly, input int rv_dly, input logic [31:0] data);
    PC = pc;
    fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0;
    chk("req_asserted", {31'd0, mem_req}, 32'd1);
    chk("req_addr", mem_addr, exp_addr);
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      chk("req_held", {31'd0, mem_req}, 32'd1);
      chk("addr_stable", mem_addr, exp_addr);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("req_dropped_after_gnt", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < rv_dly; i++) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    sb_q.push_back({1'b0, data});
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    chk("valid_pulse", {31'd0, fetch_valid}, 32'd1);
    tick();
    chk("valid_one_cycle", {31'd0, fetch_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    resetn = 1'b0;
    PC = 32'h0; fetch_enable = 1'b0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #12;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr", instr_fetch, 32'h0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_timeout", {31'd0, fetch_timeout}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Basic fetch, then a stalled grant.
    do_fetch(32'h0000_1000, 32'h0000_1000, 0, 0, 32'h0050_0093);
    chk("basic_instr_held", instr_fetch, 32'h0050_0093);
    do_fetch(32'h0000_1004, 32'h0000_1004, 5, 0, 32'h0010_8093);

    // Flush in IDLE with fetch_enable: ignored.
    PC = 32'h0000_5555_0000; fetch_enable = 1'b1; flush = 1'b1;
    tick();
    fetch_enable = 1'b0; flush = 1'b0;
    chk("idle_flush_no_req", {31'd0, mem_req}, 32'd0);

    // Flush in WAIT; late data discarded.
    PC = 32'h0000_3000; fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("flush_wait_no_valid", {31'd0, fetch_valid}, 32'd0);
    chk("flush_wait_instr_kept", instr_fetch, 32'h0010_8093);
    do_fetch(32'h0000_2000, 32'h0000_2000, 0, 1, 32'h00A0_0113);

    // Flush while in REQ (before grant) kills the response.
    PC = 32'h0000_2004; fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("req_held_after_flush", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0001;
    tick();
    mem_rvalid = 1'b0;
    chk("flush_req_no_valid", {31'd0, fetch_valid}, 32'd0);
    chk("flush_req_instr_kept", instr_fetch, 32'h00A0_0113);

    // Watchdog: 8 cycles in WAIT with no response.
    PC = 32'h0000_4000; fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("timeout_not_yet", {31'd0, fetch_timeout}, 32'd0);
    end
    tick();
    chk("timeout_fired", {31'd0, fetch_timeout}, 32'd1);
    PC = 32'h0000_4100; fetch_enable = 1'b1;
    tick(); tick();
    chk("drop_no_new_req", {31'd0, mem_req}, 32'd0);
    fetch_enable = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_discarded", {31'd0, fetch_valid}, 32'd0);
    do_fetch(32'h0000_4200, 32'h0000_4200, 0, 0, 32'h0020_0193);
    chk("timeout_sticky", {31'd0, fetch_timeout}, 32'd1);

    // Reset while in WAIT; response after reset ignored.
    PC = 32'h0000_6000; fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    resetn = 1'b0;
    #2;
    chk("midrst_instr", instr_fetch, 32'h0);
    chk("midrst_timeout", {31'd0, fetch_timeout}, 32'd0);
    tick();
    resetn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk("postrst_no_valid", {31'd0, fetch_valid}, 32'd0);
    chk("postrst_instr", instr_fetch, 32'h0);
    chk("postrst_no_req", {31'd0, mem_req}, 32'd0);
    chk("postrst_addr", mem_addr, 32'h0);

    // Misaligned PC.
`ifdef FETCH_MISALIGN_TRAP_EN
    PC = 32'h0000_1002; fetch_enable = 1'b1;
    sb_q.push_back({1'b1, 32'h0000_0013});
    tick();
    fetch_enable = 1'b0;
    chk("mis_no_req", {31'd0, mem_req}, 32'd0);
    chk("mis_valid", {31'd0, fetch_valid}, 32'd1);
    chk("mis_flag", {31'd0, fetch_misaligned_w}, 32'd1);
    chk("mis_nop", instr_fetch, 32'h0000_0013);
    tick();
    chk("mis_flag_clears", {31'd0, fetch_misaligned_w}, 32'd0);
`else
    do_fetch(32'h0000_1002, 32'h0000_1000, 0, 0, 32'h0000_0513);
`endif

    tick(); tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
